// File: rtl/program_loader.sv
// Loads a length-prefixed, big-endian program image from the UART byte stream
// into instruction memory, one 32-bit word per write.
module program_loader #(
    parameter int INST_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic                 ferr,
    output logic                 imem_we,
    output logic [INST_SIZE-1:0] imem_addr,
    output logic [31:0]          imem_din,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          count,
    output logic [31:0]          checksum,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [31:0]        MAX_WORDS = 32'd1 << INST_SIZE;
    localparam logic [INST_SIZE:0] IDX_ONE   = (INST_SIZE+1)'(1);

    state_t                 state_q;
    logic [1:0]             byte_cnt_q;
    logic [31:0]            word_q;
    logic [31:0]            word_d;
    logic [INST_SIZE:0]     len_q;
    logic [INST_SIZE:0]     idx_q;
    logic                   imem_we_q;
    logic [INST_SIZE-1:0]   imem_addr_q;
    logic [31:0]            imem_din_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [31:0]            count_q;
    logic [31:0]            checksum_q;

    // The word including the byte on rx_data; used whenever the 4th byte arrives.
    assign word_d = {word_q[23:0], rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'd0;
            len_q       <= '0;
            idx_q       <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_din_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= 32'd0;
            checksum_q  <= 32'd0;
        end else begin
            imem_we_q <= 1'b0;
            if (start && !busy_q) begin
                state_q    <= S_LEN;
                byte_cnt_q <= 2'd0;
                idx_q      <= '0;
                count_q    <= 32'd0;
                checksum_q <= 32'd0;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
            end else if (busy_q && rx_ready) begin
                if (ferr) begin
                    // Faulty byte is dropped; earlier writes and totals stand.
                    state_q <= S_ERR;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                end else begin
                    word_q     <= word_d;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == S_LEN) begin
                            if (word_d == 32'd0) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (word_d > MAX_WORDS) begin
                                state_q <= S_ERR;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                len_q   <= word_d[INST_SIZE:0];
                                state_q <= S_DATA;
                            end
                        end else begin
                            imem_we_q   <= 1'b1;
                            imem_addr_q <= idx_q[INST_SIZE-1:0];
                            imem_din_q  <= word_d;
                            count_q     <= count_q + 32'd1;
                            checksum_q  <= checksum_q + word_d;
                            idx_q       <= idx_q + IDX_ONE;
                            if (idx_q + IDX_ONE == len_q) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_din  = imem_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;
    assign checksum  = checksum_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random images, per-byte status checks
// and a write scoreboard fed by an arithmetic model of the load protocol.
module tb_program_loader;

    localparam int IS   = 10;
    localparam int MAXW = 1 << IS;
    localparam int EW   = IS + 96;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          ferr;
    logic          imem_we;
    logic [IS-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   count;
    logic [31:0]   checksum;
    logic [2:0]    state_dbg;

    program_loader #(.INST_SIZE(IS)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_ready(rx_ready), .ferr(ferr), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_din(imem_din), .busy(busy),
        .done(done), .err(err), .count(count), .checksum(checksum),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_total = 0;
    int            n_bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [3:0]    st_exp[$];
    logic [7:0]    img[$];
    int            fe_pos;
    int            start_at;
    logic [31:0]   m_count;
    logic [31:0]   m_sum;
    logic          m_done;
    logic          m_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: derives, from the byte list alone, the expected writes
    // and the {we,busy,done,err} status seen one cycle after every byte.
    task automatic model();
        int          fe;
        int          end_b;
        longint      n;
        bit          nvalid;
        logic [31:0] w;
        logic [3:0]  s;
        st_exp.delete();
        exp_q.delete();
        m_count = 0;
        m_sum   = 0;
        m_done  = 0;
        m_err   = 0;
        fe = (fe_pos < 0) ? 32'h3fffffff : fe_pos;
        n  = 0;
        if (fe >= 4 && img.size() >= 4) n = {img[0], img[1], img[2], img[3]};
        nvalid = (fe >= 4 && img.size() >= 4) && n != 0 && n <= MAXW;
        if (fe < 4 || img.size() < 4) end_b = 32'h3fffffff;
        else if (!nvalid)             end_b = 3;
        else                          end_b = int'(4 * n + 3);
        for (int k = 0; k < img.size(); k++) begin
            s = 4'b0000;
            if (fe <= end_b && k >= fe) s[2:0] = 3'b001;
            else if (k >= end_b)       s[2:0] = {1'b0, (n <= MAXW), (n > MAXW)};
            else                       s[2:0] = 3'b100;
            if (nvalid && k < fe && k >= 4 && k % 4 == 3 && k <= end_b) begin
                w = {img[k-3], img[k-2], img[k-1], img[k]};
                m_count = m_count + 1;
                m_sum   = m_sum + w;
                exp_q.push_back({IS'(k / 4 - 1), w, m_count, m_sum});
                s[3] = 1'b1;
            end
            st_exp.push_back(s);
            m_done = s[1];
            m_err  = s[0];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_status(input int k);
        check("byte_status", {124'd0, imem_we, busy, done, err}, {124'd0, st_exp[k]});
    endtask

    task automatic drive_image(input int gap);
        for (int k = 0; k < img.size(); k++) begin
            @(negedge clk);
            if (gap == 0 && k > 0) check_status(k - 1);
            start    = (k == start_at);
            rx_ready = 1'b1;
            rx_data  = img[k];
            ferr     = (k == fe_pos);
            if (gap > 0) begin
                @(negedge clk);
                start = 1'b0; rx_ready = 1'b0; ferr = 1'b0;
                check_status(k);
                repeat (gap - 1) @(negedge clk);
            end
        end
        if (gap == 0 && img.size() > 0) begin
            @(negedge clk);
            start = 1'b0; rx_ready = 1'b0; ferr = 1'b0;
            check_status(img.size() - 1);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("reset_values",
              {imem_we, imem_addr, imem_din, busy, done, err, count, checksum}, 128'd0);
    endtask

    task automatic build_image(input int n, input int trail);
        img.delete();
        img.push_back(8'(n >> 24)); img.push_back(8'(n >> 16));
        img.push_back(8'(n >> 8));  img.push_back(8'(n));
        for (int i = 0; i < 4 * n + trail; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic finish_check();
        repeat (3) @(negedge clk);
        check("writes_left", 128'(exp_q.size()), 128'd0);
        check("count", {96'd0, count}, {96'd0, m_count});
        check("checksum", {96'd0, checksum}, {96'd0, m_sum});
        check("flags", {125'd0, busy, done, err},
              {125'd0, !(m_done || m_err), m_done, m_err});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, none required", imem_addr, imem_din);
            end else begin
                e = exp_q.pop_front();
                check("write", {22'd0, imem_addr, imem_din, count, checksum}, {22'd0, e});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; rx_ready = 1'b0; ferr = 1'b0; rx_data = 8'd0;
        fe_pos = -1; start_at = -1;
        repeat (2) @(negedge clk);
        check("reset_values",
              {imem_we, imem_addr, imem_din, busy, done, err, count, checksum}, 128'd0);
        rst = 1'b0;

        // normal load, slow bytes
        img = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                8'hAC, 8'h01, 8'h00, 8'h00};
        model();
        pulse_start();
        drive_image(1000);
        finish_check();
        check("normal_sum", {96'd0, checksum}, {96'd0, 32'hCC020005});
        check("normal_count", {96'd0, count}, 128'd2);

        // zero length, then stray bytes
        img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        model();
        pulse_start();
        drive_image(0);
        finish_check();

        // oversize length, then data that must be dropped
        img = '{8'h00, 8'h00, 8'h04, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05};
        model();
        pulse_start();
        drive_image(0);
        finish_check();

        // exactly full memory, back-to-back
        build_image(MAXW, 4);
        model();
        pulse_start();
        drive_image(0);
        finish_check();

        // framing error on 2nd byte of word 1
        build_image(3, 0);
        fe_pos = 9;
        model();
        pulse_start();
        drive_image(2);
        finish_check();
        check("ferr_count", {96'd0, count}, 128'd1);
        fe_pos = -1;

        // reset mid-word, then a clean reload
        img = '{8'h00, 8'h00};
        model();
        pulse_start();
        drive_image(1);
        pulse_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                8'hAC, 8'h01, 8'h00, 8'h00};
        model();
        pulse_start();
        drive_image(3);
        finish_check();

        // random images
        for (int t = 0; t < 8; t++) begin
            int nw;
            int tr;
            nw = $urandom_range(1, 6);
            tr = $urandom_range(0, 4);
            build_image(nw, tr);
            fe_pos = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4 * nw + 3 + tr) : -1;
            model();
            pulse_start();
            drive_image($urandom_range(0, 3));
            finish_check();
        end
        fe_pos = -1;

        // back-to-back with a start pulse mid-load, then restart after done
        build_image(4, 0);
        start_at = 8;
        model();
        pulse_start();
        drive_image(0);
        finish_check();
        start_at = -1;
        pulse_start();
        check("restart_flags", {125'd0, busy, done, err}, {125'd0, 3'b100});
        pulse_reset();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
